// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one ROM read per cycle while credit allows,
// buffers {pc, inst} pairs in a small circular buffer and hands the head
// entry to decode. A redirect (flush) empties the queue and restarts fetch.
module fetch_queue #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 10,
  parameter int DEPTH     = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  output logic                     rom_en,
  output logic [ADDR_SIZE-1:0]     rom_addr,
  input  logic [DATA_SIZE-1:0]     rom_data,
  input  logic                     flush,
  input  logic [ADDR_SIZE+1:0]     flush_pc,
  input  logic                     inst_ready,
  output logic                     inst_valid,
  output logic [DATA_SIZE-1:0]     inst_out,
  output logic [ADDR_SIZE+1:0]     pc_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PC_W  = ADDR_SIZE + 2;
  localparam logic [DATA_SIZE-1:0] NOP_INST = DATA_SIZE'(32'h0000_0013);

  logic [PC_W-1:0]      fetch_pc_reg, fetch_pc_next;
  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 inflight_reg, inflight_next;
  logic [PC_W-1:0]      inflight_pc_reg, inflight_pc_next;
  logic                 kill_reg, kill_next;

  logic [DATA_SIZE-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]      pc_mem   [DEPTH];

  logic                 push;
  logic                 pop;
  logic [CNT_W:0]       credit_used;

  // Byte-offset bits of the redirect target carry no information.
  logic                 unused_flush_lsbs;
  assign unused_flush_lsbs = ^flush_pc[1:0];

  // Credit check: slots already occupied plus the response still in flight.
  always_comb begin
    credit_used = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    rom_en      = RESET_N && !flush && (credit_used < (CNT_W+1)'(DEPTH));
    push        = inflight_reg && !kill_reg && !flush;
    pop         = inst_valid && inst_ready && !flush;
  end

  // Next-state: redirect wins over push/pop; otherwise advance queue and fetch PC.
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    count_next       = count_reg;
    inflight_next    = rom_en;
    inflight_pc_next = inflight_pc_reg;
    kill_next        = kill_reg;
    if (flush) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
      fetch_pc_next = {flush_pc[PC_W-1:2], 2'b00};
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
      if (rom_en) fetch_pc_next = fetch_pc_reg + PC_W'(4);
    end
    // A fresh request is always live; a redirect marks anything outstanding stale.
    if (rom_en) begin
      inflight_pc_next = fetch_pc_reg;
      kill_next        = 1'b0;
    end else if (flush) begin
      kill_next = 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fetch_pc_reg    <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      kill_reg        <= 1'b0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      kill_reg        <= kill_next;
    end
  end

  // Entry storage: the ROM response lands at the write pointer one cycle after its request.
  always_ff @(posedge CLK) begin
    if (RESET_N && push) begin
      inst_mem[wr_ptr_reg] <= rom_data;
      pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
    end
  end

  // Head presentation: NOP at PC 0 whenever the queue is empty.
  always_comb begin
    inst_valid = (count_reg != '0);
    inst_out   = inst_valid ? inst_mem[rd_ptr_reg] : NOP_INST;
    pc_out     = inst_valid ? pc_mem[rd_ptr_reg] : '0;
    count      = count_reg;
    rom_addr   = fetch_pc_reg[PC_W-1:2];
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, instruction width.
REQ-002 SHALL have parameter ADDR_SIZE, default 10, instruction ROM word-address width; the byte PC is ADDR_SIZE+2 bits.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-004 SHALL have ports:
  CLK  in  1  sole clock; all state updates on the rising edge.
  RESET_N  in  1  synchronous, active-low reset.
  rom_en  out  1  fetch request issued this cycle.
  rom_addr  out  ADDR_SIZE  ROM word address, equal to fetch_pc[ADDR_SIZE+1:2].
  rom_data  in  DATA_SIZE  ROM read data, valid exactly one cycle after rom_en.
  flush  in  1  redirect request from the branch-resolution stage.
  flush_pc  in  ADDR_SIZE+2  redirect byte target; bits [1:0] ignored.
  inst_ready  in  1  decode stage accepts the head entry (low while stalled).
  inst_valid  out  1  head entry present.
  inst_out  out  DATA_SIZE  head instruction.
  pc_out  out  ADDR_SIZE+2  byte PC of the head instruction.
  count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-005 SHALL hold fetch_pc (ADDR_SIZE+2 bits), a DEPTH-entry circular buffer of {pc, inst}, read/write pointers, an occupancy counter, and one in-flight flag plus its pc and a kill bit.
REQ-006 SHALL drive rom_en = !flush && (count + inflight < DEPTH), using registered values only.
REQ-007 SHALL, when rom_en is high, record in-flight = 1 with pc = fetch_pc and kill = 0, then advance fetch_pc by 4, wrapping modulo 2^(ADDR_SIZE+2) (0xFFC -> 0x000 at default).
REQ-008 SHALL, in the cycle after a request, write {in-flight pc, rom_data} at the write pointer unless kill is set; entries become visible on inst_valid the following cycle (no bypass).
REQ-009 SHALL pop the head when inst_valid && inst_ready; push and pop in the same cycle leave count unchanged.
REQ-010 SHALL drive inst_valid = (count != 0); inst_out = 32'h00000013 (NOP) and pc_out = 0 when count == 0.
REQ-011 SHALL never overflow: the credit rule in REQ-006 guarantees a free slot for every in-flight response; no entry is dropped under a stall of any length.
REQ-012 SHALL, on flush, in that cycle: clear count and both pointers, set kill on any in-flight request, load fetch_pc = {flush_pc[ADDR_SIZE+1:2], 2'b00}, and suppress rom_en.
REQ-013 SHALL give flush priority over a simultaneous pop or push; both are discarded.
REQ-014 SHALL give flush-to-valid latency of 3 cycles: flush at t, rom_en with rom_addr = flush_pc>>2 at t+1, rom_data at t+2, inst_valid at t+3.
REQ-015 SHALL sustain one instruction per cycle when inst_ready is held high after fill.
REQ-016 SHALL have the pointers wrap modulo DEPTH; full is count == DEPTH; empty is count == 0.

Reset
REQ-017 SHALL, while RESET_N is low at a clock edge, set fetch_pc = 0, count = 0, pointers = 0, in-flight = 0, kill = 0; rom_en = 0, inst_valid = 0, inst_out = NOP, pc_out = 0.
REQ-018 SHALL give reset priority over flush, push and pop; reset mid-operation discards all entries and any in-flight response.
REQ-019 SHALL, in the first cycle after RESET_N rises, assert rom_en with rom_addr = 0; inst_valid with pc_out = 0 rises 2 cycles later.

Verification
REQ-020 Reset release, ROM returns word index i, inst_ready = 1 -> pc_out sequence 0x000, 0x004, 0x008 on consecutive cycles, no gaps after the first valid.
REQ-021 inst_ready held 0 for 10 cycles -> count saturates at 4, rom_en low once count + inflight = 4, entries 0x000..0x00C intact; on release they pop in order with no loss.
REQ-022 Flush with flush_pc = 0x103 while 3 entries and 1 in-flight -> count = 0 next cycle, killed response not enqueued, rom_addr = 0x040 at t+1, pc_out = 0x100 at t+3.
REQ-023 Flush with inst_ready = 1 and rom response arriving in the same cycle -> neither pop nor push takes effect; count = 0 next cycle.
REQ-024 fetch_pc at 0xFF8, streaming -> pc_out 0xFF8, 0xFFC, 0x000, 0x004.
REQ-025 RESET_N low for one cycle with a full queue and a flush asserted -> next cycle count = 0, inst_valid = 0, fetch_pc = 0 (flush_pc ignored).
